stream_sched: RTL and testbench

- Round-robin scheduler that shares one serial sequence-detector instance between NUM_REQ requesters.
- Each requester presents a W-bit word. The block grants one requester, clears the detector, and shifts the word into the detector MSB-first.
- It counts the detector's match pulses (including trailing, late pulses) and returns a per-word match count tagged with the requester id.
- Sits between the requester fabric and the shared detector.

---
 rtl/stream_sched_pkg.sv | 18 +
 rtl/stream_sched_rr_arbiter.sv | 81 ++++++++
 rtl/stream_sched.sv | 152 +++++++++++++++
 tb/tb_stream_sched.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/stream_sched_pkg.sv
// stream_sched_pkg: shared types and default parameters for the stream
// scheduler. Holds the scheduler FSM state encoding and the default values
// used by stream_sched and its arbiter.
package stream_sched_pkg;

  localparam int DEF_NUM_REQ      = 4;
  localparam int DEF_W            = 8;
  localparam int DEF_DRAIN_CYCLES = 2;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    SHIFT = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } sched_state_t;

endpackage

// File: rtl/stream_sched_rr_arbiter.sv
// stream_sched_rr_arbiter: picks one requester for the scheduler.
// Default build: round-robin starting at rr_ptr, pointer moves to
// winner+1 (mod NUM_REQ) whenever a grant is taken.
// Build option STREAM_SCHED_FIXED_PRIO_EN: fixed priority, lowest index
// wins, no pointer state.
// Ports:
//   clk, rst   clock, asynchronous active-high reset
//   req        per-requester request vector
//   advance    grant is being taken this cycle (updates the pointer)
//   any_req    at least one request is pending
//   winner     index of the selected requester
//   onehot     one-hot form of winner (all zero when any_req is low)
module stream_sched_rr_arbiter
  import stream_sched_pkg::*;
#(
  parameter int  NUM_REQ = DEF_NUM_REQ,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic               advance,
  output logic               any_req,
  output logic [ID_W-1:0]    winner,
  output logic [NUM_REQ-1:0] onehot
);

`ifdef STREAM_SCHED_FIXED_PRIO_EN

  // Scan from the top down so the lowest asserted index is written last.
  always_comb begin
    any_req = 1'b0;
    winner  = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        any_req = 1'b1;
        winner  = ID_W'(i);
      end
    end
  end

`else

  logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0] idx;

  // Scan offsets from the farthest down to rr_ptr itself so the requester
  // closest to the pointer (wrapping) is the last one written.
  always_comb begin
    any_req = 1'b0;
    winner  = '0;
    idx     = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      idx = ID_W'((int'(rr_ptr_q) + i) % NUM_REQ);
      if (req[idx]) begin
        any_req = 1'b1;
        winner  = idx;
      end
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (advance && any_req) begin
      rr_ptr_d = (winner == ID_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rr_ptr_q <= '0;
    else     rr_ptr_q <= rr_ptr_d;
  end

`endif

  always_comb begin
    onehot = '0;
    if (any_req) onehot[winner] = 1'b1;
  end

endmodule

// File: rtl/stream_sched.sv
// stream_sched: shares one serial sequence detector between NUM_REQ
// requesters. A granted word is captured, the detector is cleared, the word
// is shifted out MSB-first, then DRAIN_CYCLES idle cycles catch late match
// pulses. The number of cycles det_o was high is reported with the id.
// Build option STREAM_SCHED_FIXED_PRIO_EN selects fixed-priority arbitration
// instead of round-robin.
// Ports:
//   clk, rst    clock, asynchronous active-high reset
//   req         per-requester level request
//   data        packed words, requester k at [k*W +: W]
//   gnt         one-hot grant pulse in the capture cycle
//   det_clear   one-cycle detector clear pulse
//   det_i       serial bit to the detector
//   det_o       detector match output
//   done        one-cycle result-valid pulse
//   done_id     requester whose word finished (held until the next done)
//   match_cnt   cycles det_o was high during SHIFT/DRAIN (held likewise)
module stream_sched
  import stream_sched_pkg::*;
#(
  parameter int  NUM_REQ      = DEF_NUM_REQ,
  parameter int  W            = DEF_W,
  parameter int  DRAIN_CYCLES = DEF_DRAIN_CYCLES,
  localparam int ID_W         = $clog2(NUM_REQ),
  localparam int CNT_W        = $clog2(W + DRAIN_CYCLES + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [NUM_REQ*W-1:0] data,
  output logic [NUM_REQ-1:0]   gnt,
  output logic                 det_clear,
  output logic                 det_i,
  input  logic                 det_o,
  output logic                 done,
  output logic [ID_W-1:0]      done_id,
  output logic [CNT_W-1:0]     match_cnt
);

  sched_state_t     state_q, state_d;
  logic [W-1:0]     shreg_q, shreg_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [CNT_W-1:0] match_q, match_d;
  logic [ID_W-1:0]  id_q, id_d;
  logic [ID_W-1:0]  done_id_q, done_id_d;
  logic [CNT_W-1:0] match_cnt_q, match_cnt_d;

  logic               grant_en;
  logic               any_req;
  logic [ID_W-1:0]    winner;
  logic [NUM_REQ-1:0] onehot;

  stream_sched_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .advance (grant_en),
    .any_req (any_req),
    .winner  (winner),
    .onehot  (onehot)
  );

  // NOTE: every signal written here gets a default first so no path leaves
  // it unassigned; otherwise synthesis infers a latch.
  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    bit_cnt_d   = bit_cnt_q;
    match_d     = match_q;
    id_d        = id_q;
    done_id_d   = done_id_q;
    match_cnt_d = match_cnt_q;
    grant_en    = 1'b0;
    gnt         = '0;
    det_clear   = 1'b0;
    det_i       = 1'b0;
    done        = 1'b0;

    unique case (state_q)
      IDLE: begin
        // rst gating keeps gnt low while reset is held with req active.
        if (any_req && !rst) begin
          grant_en = 1'b1;
          gnt      = onehot;
          shreg_d  = data[winner*W +: W];
          id_d     = winner;
          state_d  = CLEAR;
        end
      end
      CLEAR: begin
        det_clear = 1'b1;
        match_d   = '0;
        bit_cnt_d = '0;
        state_d   = SHIFT;
      end
      SHIFT: begin
        det_i   = shreg_q[W-1];
        shreg_d = shreg_q << 1;
        if (det_o) match_d = match_q + 1'b1;
        if (bit_cnt_q == CNT_W'(W - 1)) begin
          bit_cnt_d = '0;
          state_d   = DRAIN;
        end else begin
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
      end
      DRAIN: begin
        if (det_o) match_d = match_q + 1'b1;
        if (bit_cnt_q == CNT_W'(DRAIN_CYCLES - 1)) begin
          // Result registers load here so they are valid during the done
          // pulse, including a pulse arriving in this last drain cycle.
          done_id_d   = id_q;
          match_cnt_d = match_d;
          state_d     = DONE;
        end else begin
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      shreg_q     <= '0;
      bit_cnt_q   <= '0;
      match_q     <= '0;
      id_q        <= '0;
      done_id_q   <= '0;
      match_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      bit_cnt_q   <= bit_cnt_d;
      match_q     <= match_d;
      id_q        <= id_d;
      done_id_q   <= done_id_d;
      match_cnt_q <= match_cnt_d;
    end
  end

  assign done_id   = done_id_q;
  assign match_cnt = match_cnt_q;

endmodule

// File: tb/tb_stream_sched.sv
// tb_stream_sched: directed self-checking bench for stream_sched at default
// parameters. The bench plays the detector by driving det_o per cycle.
// Inputs change on the falling edge; outputs are sampled 1 ns later.
module tb_stream_sched;

  logic        clk;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] data;
  logic [3:0]  gnt;
  logic        det_clear;
  logic        det_i;
  logic        det_o;
  logic        done;
  logic [1:0]  done_id;
  logic [3:0]  match_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  stream_sched dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .data      (data),
    .gnt       (gnt),
    .det_clear (det_clear),
    .det_i     (det_i),
    .det_o     (det_o),
    .done      (done),
    .done_id   (done_id),
    .match_cnt (match_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // One cycle: drive inputs for this cycle, then let outputs settle.
  task automatic step(input logic [3:0] r, input logic d);
    @(negedge clk);
    req   = r;
    det_o = d;
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; req = 4'b1111; det_o = 1'b1;
    #2;
    n_checks++; if (gnt !== 4'b0000) begin n_fail++; $display("FAIL reset_gnt: got %b want 0000", gnt); end
    n_checks++; if (det_clear !== 1'b0) begin n_fail++; $display("FAIL reset_det_clear: got %b want 0", det_clear); end
    n_checks++; if (det_i !== 1'b0) begin n_fail++; $display("FAIL reset_det_i: got %b want 0", det_i); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
    n_checks++; if (done_id !== 2'd0) begin n_fail++; $display("FAIL reset_done_id: got %0d want 0", done_id); end
    n_checks++; if (match_cnt !== 4'd0) begin n_fail++; $display("FAIL reset_match_cnt: got %0d want 0", match_cnt); end
    @(negedge clk);
    rst = 1'b0; req = 4'b0000; det_o = 1'b0;
  endtask

  task automatic test_single;
    logic [7:0] pat = 8'hB4;
    logic       exp_di;
    step(4'b0001, 1'b0);
    n_checks++; if (gnt !== 4'b0001) begin n_fail++; $display("FAIL single_gnt: got %b want 0001", gnt); end
    for (int k = 1; k <= 12; k++) begin
      step(4'b0000, (k == 3) || (k == 7));
      exp_di = (k >= 2 && k <= 9) ? pat[9-k] : 1'b0;
      n_checks++; if (det_i !== exp_di) begin n_fail++; $display("FAIL single_det_i k=%0d: got %b want %b", k, det_i, exp_di); end
      n_checks++; if (det_clear !== (k == 1)) begin n_fail++; $display("FAIL single_det_clear k=%0d: got %b want %b", k, det_clear, (k == 1)); end
      n_checks++; if (done !== (k == 12)) begin n_fail++; $display("FAIL single_done k=%0d: got %b want %b", k, done, (k == 12)); end
      if (k == 12) begin
        n_checks++; if (done_id !== 2'd0) begin n_fail++; $display("FAIL single_done_id: got %0d want 0", done_id); end
        n_checks++; if (match_cnt !== 4'd2) begin n_fail++; $display("FAIL single_match_cnt: got %0d want 2", match_cnt); end
      end
    end
    step(4'b0000, 1'b0);
  endtask

  // det_o high in CLEAR (k=1), 2nd DRAIN (k=11) and DONE (k=12): only k=11 counts.
  task automatic test_late_pulse;
    step(4'b0010, 1'b0);
    n_checks++; if (gnt !== 4'b0010) begin n_fail++; $display("FAIL late_gnt: got %b want 0010", gnt); end
    for (int k = 1; k <= 13; k++) begin
      step(4'b0000, (k == 1) || (k == 11) || (k == 12));
      if (k == 12) begin
        n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL late_done: got %b want 1", done); end
        n_checks++; if (done_id !== 2'd1) begin n_fail++; $display("FAIL late_done_id: got %0d want 1", done_id); end
        n_checks++; if (match_cnt !== 4'd1) begin n_fail++; $display("FAIL late_match_cnt: got %0d want 1", match_cnt); end
      end
      if (k == 13) begin
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL late_done_after: got %b want 0", done); end
        n_checks++; if (match_cnt !== 4'd1) begin n_fail++; $display("FAIL late_match_hold: got %0d want 1", match_cnt); end
      end
    end
  endtask

  task automatic test_request_drop;
    int extra_gnt = 0;
    step(4'b0100, 1'b0);
    n_checks++; if (gnt !== 4'b0100) begin n_fail++; $display("FAIL drop_gnt: got %b want 0100", gnt); end
    for (int k = 1; k <= 14; k++) begin
      step(4'b0000, 1'b0);
      if (gnt !== 4'b0000) extra_gnt++;
      if (k == 12) begin
        n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL drop_done: got %b want 1", done); end
        n_checks++; if (done_id !== 2'd2) begin n_fail++; $display("FAIL drop_done_id: got %0d want 2", done_id); end
        n_checks++; if (match_cnt !== 4'd0) begin n_fail++; $display("FAIL drop_match_cnt: got %0d want 0", match_cnt); end
      end
    end
    n_checks++; if (extra_gnt !== 0) begin n_fail++; $display("FAIL drop_extra_gnt: got %0d grants want 0", extra_gnt); end
  endtask

  // rr_ptr is 3 here; granting requester 0 moves it to 1, so the contention
  // test that follows sees grant 0 first only if reset returned it to 0.
  task automatic test_reset_mid_shift;
    int late_done = 0;
    step(4'b0001, 1'b0);
    n_checks++; if (gnt !== 4'b0001) begin n_fail++; $display("FAIL rms_gnt: got %b want 0001", gnt); end
    for (int k = 1; k <= 5; k++) step(4'b0000, 1'b0);
    n_checks++; if (det_i !== 1'b1) begin n_fail++; $display("FAIL rms_det_i_pre: got %b want 1", det_i); end
    rst = 1'b1; req = 4'b0001;
    #1;
    n_checks++; if (gnt !== 4'b0000) begin n_fail++; $display("FAIL rms_gnt_rst: got %b want 0000", gnt); end
    n_checks++; if (det_i !== 1'b0) begin n_fail++; $display("FAIL rms_det_i: got %b want 0", det_i); end
    n_checks++; if (det_clear !== 1'b0) begin n_fail++; $display("FAIL rms_det_clear: got %b want 0", det_clear); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL rms_done: got %b want 0", done); end
    n_checks++; if (done_id !== 2'd0) begin n_fail++; $display("FAIL rms_done_id: got %0d want 0", done_id); end
    n_checks++; if (match_cnt !== 4'd0) begin n_fail++; $display("FAIL rms_match_cnt: got %0d want 0", match_cnt); end
    @(negedge clk);
    rst = 1'b0; req = 4'b0000;
    for (int k = 0; k < 14; k++) begin
      step(4'b0000, 1'b0);
      if (done !== 1'b0) late_done++;
    end
    n_checks++; if (late_done !== 0) begin n_fail++; $display("FAIL rms_no_done: got %0d done pulses want 0", late_done); end
  endtask

  // Collects the first n grants under a held request and checks id/spacing.
  task automatic grants_held(input string name, input logic [3:0] r, input int n_exp,
                             input int exp_id0, input int exp_id1, input int exp_id2,
                             input int exp_id3, input int exp_id4);
    int         g_cycle [5];
    logic [3:0] g_vec [5];
    int         exp_id [5];
    logic [3:0] e;
    int         n = 0;
    exp_id = '{exp_id0, exp_id1, exp_id2, exp_id3, exp_id4};
    for (int c = 0; c < 80 && n < n_exp; c++) begin
      step(r, 1'b0);
      if (gnt !== 4'b0000) begin
        g_cycle[n] = c;
        g_vec[n]   = gnt;
        n++;
      end
    end
    n_checks++; if (n !== n_exp) begin n_fail++; $display("FAIL %s_count: got %0d grants want %0d", name, n, n_exp); end
    if (n > 0) begin
      n_checks++; if (g_cycle[0] !== 0) begin n_fail++; $display("FAIL %s_first_cycle: got %0d want 0", name, g_cycle[0]); end
    end
    for (int i = 0; i < n; i++) begin
      e = 4'b0001 << exp_id[i];
      n_checks++; if (g_vec[i] !== e) begin n_fail++; $display("FAIL %s_gnt%0d: got %b want %b", name, i, g_vec[i], e); end
      if (i > 0) begin
        n_checks++;
        if (g_cycle[i] - g_cycle[i-1] !== 13) begin
          n_fail++; $display("FAIL %s_gap%0d: got %0d want 13", name, i, g_cycle[i] - g_cycle[i-1]);
        end
      end
    end
    for (int k = 0; k < 13; k++) step(4'b0000, 1'b0);
  endtask

  task automatic test_contention;
    grants_held("contention", 4'b1111, 5, 0, 1, 2, 3, 0);
  endtask

  task automatic test_fixed_prio;
    grants_held("fixed_prio", 4'b0101, 3, 0, 0, 0, 0, 0);
  endtask

  initial begin
    data = {8'h3C, 8'h5A, 8'hC3, 8'hB4};
    test_reset();
    test_single();
    test_late_pulse();
    test_request_drop();
    test_reset_mid_shift();
`ifdef STREAM_SCHED_FIXED_PRIO_EN
    test_fixed_prio();
`else
    test_contention();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
